uart_boot_top: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_if.sv | 12 +
 rtl/uart_rx.sv | 99 +++++++++
 rtl/uart_tx.sv | 97 +++++++++
 rtl/uart_boot_top.sv | 103 ++++++++++
 tb/tb_uart_boot_top.sv | 297 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART boot path.
// Holds the RX/TX state enums, frame width and the loader end marker.
package uart_pkg;

    localparam int          DATA_BITS  = 8;
    localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_if.sv
// Byte stream bundle between UART blocks.
// Ports: valid (1-cycle strobe), data[7:0]; master drives, slave reads.
interface uart_if;
    import uart_pkg::*;

    logic                 valid;
    logic [DATA_BITS-1:0] data;

    modport master (output valid, output data);
    modport slave  (input  valid, input  data);

endinterface

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop synchroniser, start-glitch filter, centre sampling.
// Ports: clk, rstn, i_rxd (serial in), m_rx (byte strobe out).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_rxd,
    uart_if.master m_rx
);

    localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    rx_state_t            r_state;
    rx_state_t            w_state;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt;
    logic [2:0]           r_bit;
    logic [2:0]           w_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift;
    logic                 r_valid;
    logic                 w_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_valid <= w_valid;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt + 1'b1;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_valid = 1'b0;
        unique case (r_state)
            RX_IDLE: begin
                w_cnt = '0;
                if (r_prev && !r_sync2)
                    w_state = RX_START;
            end
            RX_START: begin
                // Line back high at the start-bit centre means a glitch.
                if (r_cnt == HALF_M1) begin
                    w_cnt   = '0;
                    w_bit   = '0;
                    w_state = r_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt   = '0;
                    w_shift = {r_sync2, r_shift[DATA_BITS-1:1]};
                    w_bit   = r_bit + 1'b1;
                    if (r_bit == LAST_BIT)
                        w_state = RX_STOP;
                end
            end
            RX_STOP: begin
                // A low stop bit is a framing error: drop the byte.
                if (r_cnt == FULL_M1) begin
                    w_cnt   = '0;
                    w_valid = r_sync2;
                    w_state = RX_IDLE;
                end
            end
            default: w_state = RX_IDLE;
        endcase
    end

    assign m_rx.valid = r_valid;
    assign m_rx.data  = r_shift;

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter with registered line output.
// Ports: clk, rstn, s_tx (byte in, taken when idle), o_txd, o_tx_busy.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434
) (
    input  logic clk,
    input  logic rstn,
    uart_if.slave s_tx,
    output logic o_txd,
    output logic o_tx_busy
);

    localparam int CW = $clog2(2 * CLK_PER_HALF_BIT);
    localparam logic [CW-1:0] FULL_M1 = CW'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t            r_state;
    tx_state_t            w_state;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt;
    logic [2:0]           r_bit;
    logic [2:0]           w_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift;
    logic                 r_txd;
    logic                 w_txd;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_txd   <= w_txd;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt + 1'b1;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_txd   = r_txd;
        unique case (r_state)
            TX_IDLE: begin
                w_cnt = '0;
                w_txd = 1'b1;
                if (s_tx.valid) begin
                    w_shift = s_tx.data;
                    w_txd   = 1'b0;
                    w_state = TX_START;
                end
            end
            TX_START: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt   = '0;
                    w_bit   = '0;
                    w_txd   = r_shift[0];
                    w_shift = r_shift >> 1;
                    w_state = TX_DATA;
                end
            end
            TX_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt = '0;
                    w_bit = r_bit + 1'b1;
                    if (r_bit == LAST_BIT) begin
                        w_txd   = 1'b1;
                        w_state = TX_STOP;
                    end else begin
                        w_txd   = r_shift[0];
                        w_shift = r_shift >> 1;
                    end
                end
            end
            TX_STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt   = '0;
                    w_state = TX_IDLE;
                end
            end
            default: w_state = TX_IDLE;
        endcase
    end

    assign o_txd     = r_txd;
    assign o_tx_busy = (r_state != TX_IDLE);

endmodule

// File: rtl/uart_boot_top.sv
// Serial boot top: UART RX, byte echo on TX, big-endian word loader into imem.
// Ports: rxd (serial in), txd (echo out), clk (100 MHz), rstn (async, low).
module uart_boot_top
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 434,
    parameter int IMEM_DEPTH       = 1024
) (
    input  logic rxd,
    output logic txd,
    input  logic clk,
    input  logic rstn
);

    localparam int WW = $clog2(IMEM_DEPTH + 1);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam logic [WW-1:0] LAST_ADDR = WW'(IMEM_DEPTH - 1);

    uart_if w_rx ();
    uart_if w_tx ();

    logic w_tx_busy;

    uart_rx #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_rx (
        .clk  (clk),
        .rstn (rstn),
        .i_rxd(rxd),
        .m_rx (w_rx.master)
    );

    uart_tx #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_tx (
        .clk      (clk),
        .rstn     (rstn),
        .s_tx     (w_tx.slave),
        .o_txd    (txd),
        .o_tx_busy(w_tx_busy)
    );

    // One-entry echo buffer; a new byte overwrites an unsent one.
    logic                 r_buf_full;
    logic [DATA_BITS-1:0] r_buf_data;

    assign w_tx.valid = r_buf_full & ~w_tx_busy;
    assign w_tx.data  = r_buf_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf_full <= 1'b0;
            r_buf_data <= '0;
        end else if (w_rx.valid) begin
            r_buf_full <= 1'b1;
            r_buf_data <= w_rx.data;
        end else if (w_tx.valid) begin
            r_buf_full <= 1'b0;
        end
    end

    logic [1:0]    r_bcnt;
    logic [23:0]   r_word;
    logic [WW-1:0] waddr;
    logic          load_done;
    logic [31:0]   imem [IMEM_DEPTH];

    logic [31:0]   w_word;
    logic          w_take;
    logic          w_last;
    logic          w_we;

    assign w_word = {r_word, w_rx.data};
    assign w_take = w_rx.valid & ~load_done;
    assign w_last = w_take & (r_bcnt == 2'd3);
    assign w_we   = w_last & (w_word != END_MARKER);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bcnt    <= '0;
            r_word    <= '0;
            waddr     <= '0;
            load_done <= 1'b0;
        end else if (w_take) begin
            r_bcnt <= r_bcnt + 1'b1;
            r_word <= w_word[23:0];
            if (w_we) begin
                waddr <= waddr + 1'b1;
                if (waddr == LAST_ADDR)
                    load_done <= 1'b1;
            end else if (w_last) begin
                load_done <= 1'b1;
            end
        end
    end

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_we)
            imem[waddr[AW-1:0]] <= w_word;
    end

endmodule

// File: tb/tb_uart_boot_top.sv
// Self-checking bench for uart_boot_top at a shortened bit period.
// Ports: none; drives rxd, decodes txd, probes waddr/load_done/imem.
module tb_uart_boot_top;
    import uart_pkg::*;

    localparam int HALF = 16;
    localparam int BIT  = 2 * HALF;
    localparam int PER  = 10;

    typedef struct {
        logic [31:0] word;
        int          gap;
        int          idx;
        logic [31:0] exp_mem;
        logic [31:0] exp_waddr;
        logic        exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rstn;
    logic rxd_a;
    logic rxd_b;
    logic txd_a;
    logic txd_b;

    int checks   = 0;
    int failures = 0;
    int low_cnt  = 0;
    int l0;

    logic [7:0]  echo_q [$];
    longint      fall_q [$];
    longint      t_rx;
    logic [31:0] tw;
    vec_t        tbl [6];

    uart_if echo_if ();

    always #(PER / 2) clk = ~clk;

    uart_boot_top #(
        .CLK_PER_HALF_BIT(HALF)
    ) dut (
        .rxd (rxd_a),
        .txd (txd_a),
        .clk (clk),
        .rstn(rstn)
    );

    uart_boot_top #(
        .CLK_PER_HALF_BIT(HALF),
        .IMEM_DEPTH      (2)
    ) dut2 (
        .rxd (rxd_b),
        .txd (txd_b),
        .clk (clk),
        .rstn(rstn)
    );

    always @(negedge clk)
        if (!txd_a)
            low_cnt <= low_cnt + 1;

    always @(posedge clk)
        if (echo_if.valid)
            echo_q.push_back(echo_if.data);

    // Independent 8N1 receiver on the echo line.
    initial begin
        logic [7:0] db;
        echo_if.valid = 1'b0;
        echo_if.data  = '0;
        forever begin
            @(negedge txd_a);
            fall_q.push_back($time);
            repeat (HALF) @(posedge clk);
            if (txd_a)
                continue;
            for (int i = 0; i < DATA_BITS; i++) begin
                repeat (BIT) @(posedge clk);
                db[i] = txd_a;
            end
            repeat (BIT) @(posedge clk);
            if (txd_a) begin
                @(negedge clk);
                echo_if.data  = db;
                echo_if.valid = 1'b1;
                @(negedge clk);
                echo_if.valid = 1'b0;
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input int line, input logic v);
        if (line == 0) rxd_a = v;
        else           rxd_b = v;
    endtask

    task automatic send_byte(input int line, input logic [7:0] b,
                             input logic sb, input int gap);
        @(posedge clk);
        #1 drive(line, 1'b0);
        t_rx = $time;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 drive(line, b[i]);
            repeat (BIT) @(posedge clk);
        end
        #1 drive(line, sb);
        repeat (BIT) @(posedge clk);
        #1 drive(line, 1'b1);
        repeat (gap * BIT) @(posedge clk);
    endtask

    task automatic send_word(input int line, input logic [31:0] w,
                             input int gap);
        for (int k = 0; k < 4; k++)
            send_byte(line, w[31-8*k -: 8], 1'b1, gap);
    endtask

    task automatic wait_echo(input int n);
        int c = 0;
        while (echo_q.size() < n && c < 40 * BIT) begin
            @(posedge clk);
            c++;
        end
        #1 check("echo_count", echo_q.size(), n);
    endtask

    task automatic pop_check(input string nm, input logic [7:0] exp);
        logic [31:0] act;
        if (echo_q.size() > 0) act = {24'h0, echo_q.pop_front()};
        else                   act = 32'h100;
        check(nm, act, {24'h0, exp});
    endtask

    task automatic echo_word(input string nm, input logic [31:0] w);
        for (int k = 0; k < 4; k++)
            pop_check($sformatf("%s_b%0d", nm, k), w[31-8*k -: 8]);
    endtask

    task automatic do_reset();
        #1 rstn = 1'b0;
        rxd_a = 1'b1;
        rxd_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);
        echo_q.delete();
        fall_q.delete();
    endtask

    initial begin
        longint d;

        tbl[0] = '{32'h1234_5678, 5, 0, 32'h1234_5678, 32'd1, 1'b0};
        tbl[1] = '{32'hA5C3_0F81, 2, 1, 32'hA5C3_0F81, 32'd2, 1'b0};
        tbl[2] = '{32'h0000_0001, 2, 2, 32'h0000_0001, 32'd3, 1'b0};
        tbl[3] = '{32'hFFFF_FFFE, 2, 3, 32'hFFFF_FFFE, 32'd4, 1'b0};
        tbl[4] = '{32'hFFFF_FFFF, 2, 3, 32'hFFFF_FFFE, 32'd4, 1'b1};
        tbl[5] = '{32'hDEAD_BEEF, 2, 3, 32'hFFFF_FFFE, 32'd4, 1'b1};

        rstn  = 1'b0;
        rxd_a = 1'b1;
        rxd_b = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_txd", {31'h0, txd_a}, 32'd1);
        check("rst_txd2", {31'h0, txd_b}, 32'd1);
        do_reset();
        check("rst_waddr", 32'(dut.waddr), 32'd0);
        check("rst_done", {31'h0, dut.load_done}, 32'd0);

        // Single byte echo and its latency.
        send_byte(0, 8'h54, 1'b1, 2);
        wait_echo(1);
        pop_check("echo_T", 8'h54);
        d = (fall_q.size() > 0) ? (fall_q[0] - t_rx) / PER : 0;
        check("echo_lat_ok",
              {31'h0, (d >= 19 * HALF - 4) && (d <= 19 * HALF + 12)},
              32'd1);
        check("T_waddr", 32'(dut.waddr), 32'd0);

        do_reset();
        for (int v = 0; v < 6; v++) begin
            tw = tbl[v].word;
            send_word(0, tw, tbl[v].gap);
            wait_echo(4);
            echo_word($sformatf("echo_v%0d", v), tw);
            check($sformatf("mem_v%0d", v),
                  dut.imem[tbl[v].idx], tbl[v].exp_mem);
            check($sformatf("waddr_v%0d", v),
                  32'(dut.waddr), tbl[v].exp_waddr);
            check($sformatf("done_v%0d", v),
                  {31'h0, dut.load_done}, {31'h0, tbl[v].exp_done});
        end

        // End marker stops loading; imem[1] keeps its earlier word.
        do_reset();
        send_word(0, 32'h0000_0001, 2);
        send_word(0, 32'hFFFF_FFFF, 2);
        send_word(0, 32'h9988_7766, 2);
        wait_echo(12);
        echo_word("echo_c0", 32'h0000_0001);
        echo_word("echo_c1", 32'hFFFF_FFFF);
        echo_word("echo_c2", 32'h9988_7766);
        check("c_mem0", dut.imem[0], 32'h0000_0001);
        check("c_mem1", dut.imem[1], 32'hA5C3_0F81);
        check("c_waddr", 32'(dut.waddr), 32'd1);
        check("c_done", {31'h0, dut.load_done}, 32'd1);

        // Short low pulse, then a frame with a low stop bit.
        do_reset();
        l0 = low_cnt;
        @(posedge clk);
        #1 rxd_a = 1'b0;
        repeat (HALF - 6) @(posedge clk);
        #1 rxd_a = 1'b1;
        repeat (20 * BIT) @(posedge clk);
        check("glitch_txd_low", 32'(low_cnt - l0), 32'd0);
        check("glitch_echo", echo_q.size(), 32'd0);
        send_byte(0, 8'hA5, 1'b0, 2);
        repeat (15 * BIT) @(posedge clk);
        check("frm_txd_low", 32'(low_cnt - l0), 32'd0);
        check("frm_echo", echo_q.size(), 32'd0);
        send_byte(0, 8'h11, 1'b1, 2);
        send_byte(0, 8'h22, 1'b1, 2);
        send_byte(0, 8'h33, 1'b1, 2);
        wait_echo(3);
        pop_check("frm_e0", 8'h11);
        pop_check("frm_e1", 8'h22);
        pop_check("frm_e2", 8'h33);
        check("frm_waddr3", 32'(dut.waddr), 32'd0);
        send_byte(0, 8'h44, 1'b1, 2);
        wait_echo(1);
        pop_check("frm_e3", 8'h44);
        check("frm_mem0", dut.imem[0], 32'h1122_3344);
        check("frm_waddr", 32'(dut.waddr), 32'd1);

        // Reset in the middle of byte 2 while the echo is on the line.
        do_reset();
        send_byte(0, 8'h00, 1'b1, 0);
        @(posedge clk);
        #1 rxd_a = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 rxd_a = 1'b1;
            repeat (BIT) @(posedge clk);
        end
        #1 check("mid_tx_low", {31'h0, txd_a}, 32'd0);
        rstn  = 1'b0;
        rxd_a = 1'b1;
        #1 check("rst_txd_now", {31'h0, txd_a}, 32'd1);
        repeat (3) @(negedge clk);
        check("rst_txd_hold", {31'h0, txd_a}, 32'd1);
        check("rst_mid_waddr", 32'(dut.waddr), 32'd0);
        #1 rstn = 1'b1;
        repeat (14 * BIT) @(posedge clk);
        echo_q.delete();
        send_word(0, 32'hCAFE_BABE, 2);
        wait_echo(4);
        echo_word("echo_e", 32'hCAFE_BABE);
        check("e_mem0", dut.imem[0], 32'hCAFE_BABE);
        check("e_waddr", 32'(dut.waddr), 32'd1);

        // Two-word memory fills up and stops.
        send_word(1, 32'h0102_0304, 2);
        check("d2_mem0", dut2.imem[0], 32'h0102_0304);
        check("d2_done1", {31'h0, dut2.load_done}, 32'd0);
        send_word(1, 32'h0506_0708, 2);
        check("d2_mem1", dut2.imem[1], 32'h0506_0708);
        check("d2_done2", {31'h0, dut2.load_done}, 32'd1);
        send_word(1, 32'h090A_0B0C, 2);
        check("d2_mem0_keep", dut2.imem[0], 32'h0102_0304);
        check("d2_mem1_keep", dut2.imem[1], 32'h0506_0708);
        check("d2_waddr", 32'(dut2.waddr), 32'd2);
        check("d2_done", {31'h0, dut2.load_done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
